tl_gpio_bank: RTL and testbench

//  Parametrised TileLink-UL GPIO controller, successor to the fixed 32-pin GPIO. PINS-wide bank with

---
 rtl/tl_gpio_bank.sv | 245 ++++++++++++++++++++++++
 tb/tb_tl_gpio_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_gpio_bank.sv
// rtl/tl_gpio_bank.sv - TileLink-UL GPIO bank with synchronised inputs, sticky W1C pendings and atomic output set/clear
module tl_gpio_bank #(
    parameter int TL_RS       = 4,
    parameter int TL_SZ       = 4,
    parameter int PINS        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             gpio_clock_i,
    input  logic             gpio_reset_i,
    input  logic [2:0]       gpio_a_opcode,
    input  logic [2:0]       gpio_a_param,
    input  logic [TL_SZ-1:0] gpio_a_size,
    input  logic [TL_RS-1:0] gpio_a_source,
    input  logic [5:0]       gpio_a_address,
    input  logic [3:0]       gpio_a_mask,
    input  logic [31:0]      gpio_a_data,
    input  logic             gpio_a_corrupt,
    input  logic             gpio_a_valid,
    output logic             gpio_a_ready,
    output logic [2:0]       gpio_d_opcode,
    output logic [2:0]       gpio_d_param,
    output logic [TL_SZ-1:0] gpio_d_size,
    output logic [TL_RS-1:0] gpio_d_source,
    output logic             gpio_d_denied,
    output logic [31:0]      gpio_d_data,
    output logic             gpio_d_corrupt,
    output logic             gpio_d_valid,
    input  logic             gpio_d_ready,
    output logic [PINS-1:0]  gpio_int_o,
    input  logic [PINS-1:0]  gpio_input_i,
    output logic [PINS-1:0]  gpio_tristate_o,
    output logic [PINS-1:0]  gpio_output_o
);

    localparam logic [3:0] IDX_IN     = 4'd0;
    localparam logic [3:0] IDX_OUT    = 4'd1;
    localparam logic [3:0] IDX_OUTEN  = 4'd2;
    localparam logic [3:0] IDX_RIP    = 4'd3;
    localparam logic [3:0] IDX_RIE    = 4'd4;
    localparam logic [3:0] IDX_FIP    = 4'd5;
    localparam logic [3:0] IDX_FIE    = 4'd6;
    localparam logic [3:0] IDX_LIP    = 4'd7;
    localparam logic [3:0] IDX_LIE    = 4'd8;
    localparam logic [3:0] IDX_HIP    = 4'd9;
    localparam logic [3:0] IDX_HIE    = 4'd10;
    localparam logic [3:0] IDX_OUTSET = 4'd11;
    localparam logic [3:0] IDX_OUTCLR = 4'd12;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    // Input synchroniser chain and previous-sample register
    logic [SYNC_STAGES-1:0][PINS-1:0] sync_q;
    logic [PINS-1:0] prev_q;

    // Software-visible registers
    logic [PINS-1:0] out_q, out_d;
    logic [PINS-1:0] outen_q, outen_d;
    logic [PINS-1:0] rip_q, rip_d, rie_q, rie_d;
    logic [PINS-1:0] fip_q, fip_d, fie_q, fie_d;
    logic [PINS-1:0] lip_q, lip_d, lie_q, lie_d;
    logic [PINS-1:0] hip_q, hip_d, hie_q, hie_d;

    // Response channel registers
    logic             d_valid_q, d_valid_d;
    logic [2:0]       d_opcode_q, d_opcode_d;
    logic [TL_SZ-1:0] d_size_q, d_size_d;
    logic [TL_RS-1:0] d_source_q, d_source_d;
    logic             d_denied_q, d_denied_d;
    logic [31:0]      d_data_q, d_data_d;

    logic            a_fire;
    logic [3:0]      idx;
    logic            op_get, op_put, denied, wr;
    logic [31:0]     bmask32;
    logic [PINS-1:0] wm, wbits;
    logic [PINS-1:0] rdata_pins;
    logic [PINS-1:0] s, ev_en, rise, fall, low, high;
    logic            unused_inputs;

    assign unused_inputs = ^{gpio_a_param, gpio_a_address[1:0], gpio_a_data};

    assign gpio_a_ready = !d_valid_q;
    assign a_fire       = gpio_a_valid && gpio_a_ready;

    assign idx    = gpio_a_address[5:2];
    assign op_get = (gpio_a_opcode == OP_GET);
    assign op_put = (gpio_a_opcode == OP_PUT_FULL) || (gpio_a_opcode == OP_PUT_PARTIAL);
    assign denied = (idx > IDX_OUTCLR) || !(op_get || op_put);
    assign wr     = a_fire && op_put && !denied && !gpio_a_corrupt;

    assign bmask32 = {{8{gpio_a_mask[3]}}, {8{gpio_a_mask[2]}},
                      {8{gpio_a_mask[1]}}, {8{gpio_a_mask[0]}}};
    assign wm      = bmask32[PINS-1:0];
    assign wbits   = gpio_a_data[PINS-1:0] & wm;

    // Pin events; the enable uses the next OUTEN so a write freezing a pin takes effect at once
    assign s     = sync_q[SYNC_STAGES-1];
    assign ev_en = ~outen_d;
    assign rise  = ev_en & ~prev_q &  s;
    assign fall  = ev_en &  prev_q & ~s;
    assign low   = ev_en & ~prev_q & ~s;
    assign high  = ev_en &  prev_q &  s;

    // Read mux on the register index
    always_comb begin
        rdata_pins = '0;
        case (idx)
            IDX_IN:    rdata_pins = s;
            IDX_OUT:   rdata_pins = out_q;
            IDX_OUTEN: rdata_pins = outen_q;
            IDX_RIP:   rdata_pins = rip_q;
            IDX_RIE:   rdata_pins = rie_q;
            IDX_FIP:   rdata_pins = fip_q;
            IDX_FIE:   rdata_pins = fie_q;
            IDX_LIP:   rdata_pins = lip_q;
            IDX_LIE:   rdata_pins = lie_q;
            IDX_HIP:   rdata_pins = hip_q;
            IDX_HIE:   rdata_pins = hie_q;
            default:   rdata_pins = '0;
        endcase
    end

    // Register next-state: masked writes, atomic set/clear, W1C where a new event wins
    always_comb begin
        out_d   = out_q;
        outen_d = outen_q;
        rie_d   = rie_q;
        fie_d   = fie_q;
        lie_d   = lie_q;
        hie_d   = hie_q;
        if (wr) begin
            case (idx)
                IDX_OUT:    out_d   = (out_q & ~wm) | wbits;
                IDX_OUTEN:  outen_d = (outen_q & ~wm) | wbits;
                IDX_RIE:    rie_d   = (rie_q & ~wm) | wbits;
                IDX_FIE:    fie_d   = (fie_q & ~wm) | wbits;
                IDX_LIE:    lie_d   = (lie_q & ~wm) | wbits;
                IDX_HIE:    hie_d   = (hie_q & ~wm) | wbits;
                IDX_OUTSET: out_d   = out_q | wbits;
                IDX_OUTCLR: out_d   = out_q & ~wbits;
                default:    out_d   = out_q;
            endcase
        end
        rip_d = (rip_q & ~((wr && idx == IDX_RIP) ? wbits : '0)) | rise;
        fip_d = (fip_q & ~((wr && idx == IDX_FIP) ? wbits : '0)) | fall;
        lip_d = (lip_q & ~((wr && idx == IDX_LIP) ? wbits : '0)) | low;
        hip_d = (hip_q & ~((wr && idx == IDX_HIP) ? wbits : '0)) | high;
    end

    // Response next-state: capture on A fire, hold until D is taken
    always_comb begin
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_denied_d = d_denied_q;
        d_data_d   = d_data_q;
        if (d_valid_q && gpio_d_ready) begin
            d_valid_d = 1'b0;
        end
        if (a_fire) begin
            d_valid_d  = 1'b1;
            d_opcode_d = op_get ? OP_ACK_DATA : OP_ACK;
            d_size_d   = gpio_a_size;
            d_source_d = gpio_a_source;
            d_denied_d = denied;
            d_data_d   = (op_get && !denied) ? 32'(rdata_pins) : 32'd0;
        end
    end

    // Synchroniser and previous-sample flops
    always_ff @(posedge gpio_clock_i or negedge gpio_reset_i) begin
        if (!gpio_reset_i) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_input_i};
            prev_q <= s;
        end
    end

    // Register file state
    always_ff @(posedge gpio_clock_i or negedge gpio_reset_i) begin
        if (!gpio_reset_i) begin
            out_q   <= '0;
            outen_q <= '0;
            rip_q   <= '0;
            rie_q   <= '0;
            fip_q   <= '0;
            fie_q   <= '0;
            lip_q   <= '0;
            lie_q   <= '0;
            hip_q   <= '0;
            hie_q   <= '0;
        end else begin
            out_q   <= out_d;
            outen_q <= outen_d;
            rip_q   <= rip_d;
            rie_q   <= rie_d;
            fip_q   <= fip_d;
            fie_q   <= fie_d;
            lip_q   <= lip_d;
            lie_q   <= lie_d;
            hip_q   <= hip_d;
            hie_q   <= hie_d;
        end
    end

    // Response channel state; reset drops any pending response
    always_ff @(posedge gpio_clock_i or negedge gpio_reset_i) begin
        if (!gpio_reset_i) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
            d_data_q   <= '0;
        end else begin
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_denied_q <= d_denied_d;
            d_data_q   <= d_data_d;
        end
    end

    assign gpio_d_valid   = d_valid_q;
    assign gpio_d_opcode  = d_opcode_q;
    assign gpio_d_param   = 3'd0;
    assign gpio_d_size    = d_size_q;
    assign gpio_d_source  = d_source_q;
    assign gpio_d_denied  = d_denied_q;
    assign gpio_d_data    = d_data_q;
    assign gpio_d_corrupt = d_denied_q && (d_opcode_q == OP_ACK_DATA);

    assign gpio_int_o      = (rip_q & rie_q) | (fip_q & fie_q) | (lip_q & lie_q) | (hip_q & hie_q);
    assign gpio_tristate_o = outen_q;
    assign gpio_output_o   = out_q;

endmodule

// File: tb/tb_tl_gpio_bank.sv
// tb/tb_tl_gpio_bank.sv - directed scoreboard bench for tl_gpio_bank (32-pin and 8-pin instances)
module tb_tl_gpio_bank;

    typedef struct {
        logic [2:0]  op;
        logic        den;
        logic [31:0] data;
        logic        cor;
        logic [3:0]  src;
    } rsp_t;

    rsp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel8 = 1'b0;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [3:0]  a_size = 4'd2;
    logic [3:0]  a_source = '0;
    logic [5:0]  a_address = '0;
    logic [3:0]  a_mask = '0;
    logic [31:0] a_data = '0;
    logic        a_corrupt = 1'b0;
    logic        a_valid = 1'b0;
    logic        d_ready = 1'b1;
    logic [31:0] in32 = '0;
    logic [7:0]  in8 = '0;

    logic        a_valid32, a_valid8, a_ready32, a_ready8;
    logic [2:0]  d_opcode32, d_opcode8, d_param32, d_param8;
    logic [3:0]  d_size32, d_size8, d_source32, d_source8;
    logic        d_denied32, d_denied8, d_corrupt32, d_corrupt8, d_valid32, d_valid8;
    logic [31:0] d_data32, d_data8;
    logic [31:0] int32, tri32, out32;
    logic [7:0]  int8, tri8, out8;

    assign a_valid32 = a_valid && !sel8;
    assign a_valid8  = a_valid && sel8;

    logic        a_ready, d_valid, d_denied, d_corrupt;
    logic [2:0]  d_opcode;
    logic [3:0]  d_source;
    logic [31:0] d_data;
    assign a_ready   = sel8 ? a_ready8   : a_ready32;
    assign d_valid   = sel8 ? d_valid8   : d_valid32;
    assign d_denied  = sel8 ? d_denied8  : d_denied32;
    assign d_corrupt = sel8 ? d_corrupt8 : d_corrupt32;
    assign d_opcode  = sel8 ? d_opcode8  : d_opcode32;
    assign d_source  = sel8 ? d_source8  : d_source32;
    assign d_data    = sel8 ? d_data8    : d_data32;

    tl_gpio_bank #(.TL_RS(4), .TL_SZ(4), .PINS(32), .SYNC_STAGES(2)) u_dut32 (
        .gpio_clock_i(clk), .gpio_reset_i(rst_n),
        .gpio_a_opcode(a_opcode), .gpio_a_param(a_param), .gpio_a_size(a_size),
        .gpio_a_source(a_source), .gpio_a_address(a_address), .gpio_a_mask(a_mask),
        .gpio_a_data(a_data), .gpio_a_corrupt(a_corrupt), .gpio_a_valid(a_valid32),
        .gpio_a_ready(a_ready32), .gpio_d_opcode(d_opcode32), .gpio_d_param(d_param32),
        .gpio_d_size(d_size32), .gpio_d_source(d_source32), .gpio_d_denied(d_denied32),
        .gpio_d_data(d_data32), .gpio_d_corrupt(d_corrupt32), .gpio_d_valid(d_valid32),
        .gpio_d_ready(d_ready), .gpio_int_o(int32), .gpio_input_i(in32),
        .gpio_tristate_o(tri32), .gpio_output_o(out32)
    );

    tl_gpio_bank #(.TL_RS(4), .TL_SZ(4), .PINS(8), .SYNC_STAGES(2)) u_dut8 (
        .gpio_clock_i(clk), .gpio_reset_i(rst_n),
        .gpio_a_opcode(a_opcode), .gpio_a_param(a_param), .gpio_a_size(a_size),
        .gpio_a_source(a_source), .gpio_a_address(a_address), .gpio_a_mask(a_mask),
        .gpio_a_data(a_data), .gpio_a_corrupt(a_corrupt), .gpio_a_valid(a_valid8),
        .gpio_a_ready(a_ready8), .gpio_d_opcode(d_opcode8), .gpio_d_param(d_param8),
        .gpio_d_size(d_size8), .gpio_d_source(d_source8), .gpio_d_denied(d_denied8),
        .gpio_d_data(d_data8), .gpio_d_corrupt(d_corrupt8), .gpio_d_valid(d_valid8),
        .gpio_d_ready(d_ready), .gpio_int_o(int8), .gpio_input_i(in8),
        .gpio_tristate_o(tri8), .gpio_output_o(out8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One TL transaction; hold = cycles to keep d_ready low once D is valid
    task automatic access(input logic [2:0] op, input logic [5:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input logic cor, input logic [31:0] exp_data,
                          input logic exp_den, input int hold);
        rsp_t e, r;
        int n;
        logic [31:0] held;
        @(negedge clk);
        a_opcode  = op;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = cor;
        a_source  = a_source + 4'd1;
        a_valid   = 1'b1;
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.den  = exp_den;
        e.data = exp_data;
        e.cor  = exp_den && (op == 3'd4);
        e.src  = a_source;
        sb.push_back(e);
        if (hold > 0) d_ready = 1'b0;
        n = 0;
        while (!a_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_before_fire", {31'd0, a_ready}, 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("d_latency_1", {31'd0, d_valid}, 32'd1);
        n = 0;
        while (!d_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (d_valid && sb.size() > 0) begin
            r = sb.pop_front();
            chk("d_opcode",  {29'd0, d_opcode}, {29'd0, r.op});
            chk("d_denied",  {31'd0, d_denied}, {31'd0, r.den});
            chk("d_corrupt", {31'd0, d_corrupt}, {31'd0, r.cor});
            chk("d_source",  {28'd0, d_source}, {28'd0, r.src});
            chk("d_data",    d_data, r.data);
        end
        held = d_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_d_valid", {31'd0, d_valid}, 32'd1);
            chk("hold_a_ready", {31'd0, a_ready}, 32'd0);
            chk("hold_d_data",  d_data, held);
        end
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("d_released", {31'd0, d_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d_valid", {31'd0, d_valid32}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready32}, 32'd1);
        chk("rst_out", out32, 32'd0);
        chk("rst_tri", tri32, 32'd0);
        chk("rst_int", int32, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read of OUT
        access(3'd0, 6'h04, 4'hF, 32'hA5, 1'b0, 32'h0, 1'b0, 0);
        access(3'd4, 6'h04, 4'hF, 32'h0, 1'b0, 32'hA5, 1'b0, 0);
        chk("out_a5", out32, 32'hA5);

        // Atomic set/clear and masked OUTSET
        access(3'd0, 6'h04, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        access(3'd0, 6'h2C, 4'hF, 32'h0F, 1'b0, 32'h0, 1'b0, 0);
        access(3'd1, 6'h30, 4'hF, 32'h03, 1'b0, 32'h0, 1'b0, 0);
        access(3'd4, 6'h04, 4'hF, 32'h0, 1'b0, 32'h0C, 1'b0, 0);
        access(3'd1, 6'h2C, 4'h1, 32'hFF00, 1'b0, 32'h0, 1'b0, 0);
        access(3'd4, 6'h04, 4'hF, 32'h0, 1'b0, 32'h0C, 1'b0, 0);
        access(3'd4, 6'h2C, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 0);

        // Corrupt put dropped, unsupported opcode denied
        access(3'd0, 6'h04, 4'hF, 32'hFFFF, 1'b1, 32'h0, 1'b0, 0);
        access(3'd4, 6'h04, 4'hF, 32'h0, 1'b0, 32'h0C, 1'b0, 0);
        access(3'd2, 6'h04, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 0);

        // Rising-edge interrupt on pin 3
        access(3'd0, 6'h10, 4'hF, 32'h08, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        in32 = 32'h08;
        repeat (2) @(posedge clk);
        #1;
        chk("rise_int_early", {31'd0, int32[3]}, 32'd0);
        @(posedge clk);
        #1;
        chk("rise_int_set", {31'd0, int32[3]}, 32'd1);
        access(3'd4, 6'h0C, 4'hF, 32'h0, 1'b0, 32'h08, 1'b0, 0);
        access(3'd4, 6'h00, 4'hF, 32'h0, 1'b0, 32'h08, 1'b0, 0);
        access(3'd0, 6'h0C, 4'hF, 32'h08, 1'b0, 32'h0, 1'b0, 0);
        chk("rise_int_clr", {31'd0, int32[3]}, 32'd0);

        // Low-level pending on pin 5: W1C loses to the persisting event
        access(3'd0, 6'h20, 4'hF, 32'h20, 1'b0, 32'h0, 1'b0, 0);
        chk("low_int_set", {31'd0, int32[5]}, 32'd1);
        for (int i = 0; i < 3; i++)
            access(3'd0, 6'h1C, 4'hF, 32'h20, 1'b0, 32'h0, 1'b0, 0);
        access(3'd4, 6'h1C, 4'hF, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);
        chk("low_int_stuck", {31'd0, int32[5]}, 32'd1);
        access(3'd0, 6'h08, 4'hF, 32'h20, 1'b0, 32'h0, 1'b0, 0);
        chk("tri_pin5", tri32, 32'h20);
        access(3'd0, 6'h1C, 4'hF, 32'h20, 1'b0, 32'h0, 1'b0, 0);
        access(3'd4, 6'h1C, 4'hF, 32'h0, 1'b0, 32'hFFFF_FFDF, 1'b0, 0);
        chk("low_int_clr", {31'd0, int32[5]}, 32'd0);

        // Unmapped read with back-pressure
        access(3'd4, 6'h3C, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 3);
        access(3'd0, 6'h34, 4'hF, 32'hFF, 1'b0, 32'h0, 1'b1, 0);

        // 8-pin instance: bits at and above PINS read zero
        sel8 = 1'b1;
        access(3'd0, 6'h04, 4'hF, 32'hFFFF, 1'b0, 32'h0, 1'b0, 0);
        access(3'd4, 6'h04, 4'hF, 32'h0, 1'b0, 32'h00FF, 1'b0, 0);
        chk("out8_ff", {24'd0, out8}, 32'hFF);

        // Reset with a response pending
        @(negedge clk);
        a_opcode  = 3'd4;
        a_address = 6'h04;
        a_valid   = 1'b1;
        d_ready   = 1'b0;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("pend_d_valid", {31'd0, d_valid}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_mid_out8", {24'd0, out8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("no_ack_after_rst", {31'd0, d_valid}, 32'd0);
        end
        sb.delete();
        access(3'd4, 6'h04, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
